seg7_scan: RTL

Time-multiplexed driver for the Basys3 four-digit 7-segment display. It takes four active-low segment codes, such as the direction characters produced by the steering display logic, and scans them onto the shared cathode/anode lines at a fixed refresh rate. New data is double-buffered and only takes effect at a frame boundary, so the display never shows a half-updated frame. A guard interval at the start of each digit slot suppresses ghosting.

---
 rtl/seg7_scan.sv | 111 +++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - time-multiplexed four-digit 7-segment scan driver with frame-synchronous double buffering
module seg7_scan #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SLOT_HZ = 1000,
    parameter int GUARD   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] seg_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int DIV = CLK_HZ / SLOT_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [27:0]   pend_seg, act_seg;
    logic [3:0]    pend_dp, act_dp;
    logic [3:0]    pend_blank, act_blank;

    logic          last_cnt;
    logic          boundary;
    logic [6:0]    cur_seg;
    logic          en;
    logic [6:0]    seg_d;
    logic          dp_d;
    logic [3:0]    an_d;

    assign last_cnt = (cnt == CW'(DIV - 1));
    assign boundary = last_cnt && (idx == 2'd3);

    // Slot counter and digit index; slot boundaries are exact multiples of DIV.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (last_cnt) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Pending buffer takes every load; active buffer only changes at the frame boundary,
    // taking the live inputs when a load coincides with the boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_seg   <= {4{7'h7F}};
            pend_dp    <= 4'h0;
            pend_blank <= 4'hF;
            act_seg    <= {4{7'h7F}};
            act_dp     <= 4'h0;
            act_blank  <= 4'hF;
        end else begin
            if (load) begin
                pend_seg   <= seg_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
            end
            if (boundary) begin
                act_seg   <= load ? seg_in   : pend_seg;
                act_dp    <= load ? dp_in    : pend_dp;
                act_blank <= load ? blank_in : pend_blank;
            end
        end
    end

    // Select the current digit's code and decide whether the slot is driven.
    always_comb begin
        cur_seg = 7'h7F;
        case (idx)
            2'd0:    cur_seg = act_seg[6:0];
            2'd1:    cur_seg = act_seg[13:7];
            2'd2:    cur_seg = act_seg[20:14];
            default: cur_seg = act_seg[27:21];
        endcase
        en    = (cnt >= CW'(GUARD)) && !act_blank[idx];
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = 4'hF;
        if (en) begin
            seg_d = cur_seg;
            dp_d  = ~act_dp[idx];
            an_d  = ~(4'b0001 << idx);
        end
    end

    // Registered outputs so the pins never glitch between segment and anode changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= 7'h7F;
            dp         <= 1'b1;
            an         <= 4'hF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_d;
            dp         <= dp_d;
            an         <= an_d;
            frame_done <= boundary;
        end
    end

endmodule
